// File: rtl/chu_gpo_sseg_mux.sv
// Multiplexed seven-segment driver fed by a GPO slot. Patterns are double-buffered and swapped only at frame wrap.
// Optional macro SSEG_DIM_EN adds 16-level PWM brightness control per digit dwell.
module chu_gpo_sseg_mux #(
    parameter int N     = 4,
    parameter int PRESC = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [8*N-1:0] din,
    input  logic           load,
    input  logic [3:0]     bright,
    output logic [N-1:0]   an,
    output logic [7:0]     sseg,
    output logic           frame_tick
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [PRESC-1:0] presc;
    logic [IW-1:0]    idx;
    logic             tick;
    logic             wrap;
    logic [8*N-1:0]   pend;
    logic [8*N-1:0]   active;
    logic             pending;
    logic             lit;
    logic [N-1:0]     an_next;
    logic [7:0]       sseg_next;

    assign tick = &presc;
    assign wrap = tick && (idx == IW'(N - 1));

`ifdef SSEG_DIM_EN
    // Top four prescaler bits form a 16-step PWM phase within each dwell
    assign lit = (presc[PRESC-1 -: 4] < bright);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign lit           = 1'b1;
`endif

    always_comb begin
        an_next   = '1;
        sseg_next = 8'hFF;
        if (lit) begin
            an_next[idx] = 1'b0;
            sseg_next    = active[8*idx +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + 1'b1;
            if (tick)
                idx <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

    // A load coinciding with wrap keeps the pattern pending for one more frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= '1;
            active  <= '1;
            pending <= 1'b0;
        end else if (load) begin
            pend    <= din;
            pending <= 1'b1;
        end else if (wrap && pending) begin
            active  <= pend;
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_next;
            sseg       <= sseg_next;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_chu_gpo_sseg_mux.sv
// Self-checking bench for chu_gpo_sseg_mux (N=4, PRESC=4) using a cycle-count model plus literal frame checks.
// Honours SSEG_DIM_EN when defined for both model and duty-cycle expectations.
module tb_chu_gpo_sseg_mux;

    localparam int N     = 4;
    localparam int PRESC = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   din = 32'h0;
    logic          load = 1'b0;
    logic [3:0]    bright = 4'd15;
    logic [3:0]    an;
    logic [7:0]    sseg;
    logic          frame_tick;

    int checks = 0;
    int failures = 0;

    chu_gpo_sseg_mux #(.N(N), .PRESC(PRESC)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load       (load),
        .bright     (bright),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Model: position in the display derived from cycles elapsed since reset
    int         m_cycle = 0;
    logic [7:0] m_pend[4]   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] m_active[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    bit         m_pending = 0;
    logic [3:0] exp_an = 4'hF;
    logic [7:0] exp_sseg = 8'hFF;
    logic       exp_ft = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cycle   = 0;
            m_pending = 0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i]   = 8'hFF;
                m_active[i] = 8'hFF;
            end
            exp_an   = 4'hF;
            exp_sseg = 8'hFF;
            exp_ft   = 1'b0;
        end else begin
            int  phase;
            int  digit;
            bit  is_wrap;
            bit  is_lit;
            phase   = m_cycle % 16;
            digit   = (m_cycle / 16) % 4;
            is_wrap = (phase == 15) && (digit == 3);
`ifdef SSEG_DIM_EN
            is_lit = (phase < int'(bright));
`else
            is_lit = 1;
`endif
            exp_an   = is_lit ? ~(4'b0001 << digit) : 4'hF;
            exp_sseg = is_lit ? m_active[digit] : 8'hFF;
            exp_ft   = is_wrap;
            if (load) begin
                for (int i = 0; i < 4; i++) m_pend[i] = din[8*i +: 8];
                m_pending = 1;
            end else if (is_wrap && m_pending) begin
                for (int i = 0; i < 4; i++) m_active[i] = m_pend[i];
                m_pending = 0;
            end
            m_cycle++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("model_an", {28'h0, an}, {28'h0, exp_an});
            checkOutput("model_sseg", {24'h0, sseg}, {24'h0, exp_sseg});
            checkOutput("model_ft", {31'h0, frame_tick}, {31'h0, exp_ft});
        end
    end

    task automatic applyStimulus(input logic [31:0] pattern);
        din  = pattern;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic waitTick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        if (frame_tick !== 1'b1)
            checkOutput("tick_timeout", 32'd0, 32'd1);
    endtask

    // Walk one frame starting at the negedge where frame_tick is high
    task automatic checkFrame(input logic [31:0] pattern, input bit wait_tick);
        logic [3:0] an_tab[4];
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        if (wait_tick) waitTick();
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 1 : 16) @(negedge clk);
            checkOutput("frame_an", {28'h0, an}, {28'h0, an_tab[d]});
            checkOutput("frame_sseg", {24'h0, sseg}, {24'h0, pattern[8*d +: 8]});
        end
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        checkOutput("reset_an", {28'h0, an}, 32'h0000000F);
        checkOutput("reset_sseg", {24'h0, sseg}, 32'h000000FF);
        checkOutput("reset_ft", {31'h0, frame_tick}, 32'h0);
        reset = 1'b0;

        $display("[TB] blank rotation and frame period");
        waitTick();
        checkOutput("tick_an", {28'h0, an}, 32'h00000007);
        checkOutput("tick_sseg", {24'h0, sseg}, 32'h000000FF);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (frame_tick !== 1'b1 && cnt < 200);
        checkOutput("frame_period", cnt, 32'd64);

        $display("[TB] mid-frame load shows only after wrap");
        repeat (20) @(negedge clk);
        applyStimulus(32'hC0F9A4B0);
        repeat (5) @(negedge clk);
        checkOutput("no_tear_sseg", {24'h0, sseg}, 32'h000000FF);
        checkFrame(32'hC0F9A4B0, 1);

        $display("[TB] load on the wrap cycle defers by one frame");
        repeat (14) @(negedge clk);
        din  = 32'h9299B0A4;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("wrap_load_ft", {31'h0, frame_tick}, 32'h1);
        checkFrame(32'hC0F9A4B0, 0);
        checkFrame(32'h9299B0A4, 1);

        $display("[TB] back-to-back loads, last wins");
        repeat (2) @(negedge clk);
        applyStimulus(32'h11111111);
        repeat (3) @(negedge clk);
        applyStimulus(32'h22222222);
        checkFrame(32'h22222222, 1);

        $display("[TB] brightness duty");
        bright = 4'd4;
        cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (an !== 4'hF) cnt++;
        end
`ifdef SSEG_DIM_EN
        checkOutput("duty_b4", cnt, 32'd16);
`else
        checkOutput("duty_b4", cnt, 32'd64);
`endif
        bright = 4'd0;
        cnt = 0;
        repeat (64) begin
            @(negedge clk);
            if (an !== 4'hF) cnt++;
        end
`ifdef SSEG_DIM_EN
        checkOutput("duty_b0", cnt, 32'd0);
`else
        checkOutput("duty_b0", cnt, 32'd64);
`endif
        bright = 4'd15;

        $display("[TB] asynchronous reset discards pending load");
        waitTick();
        repeat (5) @(negedge clk);
        applyStimulus(32'h00000000);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_an", {28'h0, an}, 32'h0000000F);
        checkOutput("async_sseg", {24'h0, sseg}, 32'h000000FF);
        checkOutput("async_ft", {31'h0, frame_tick}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        checkFrame(32'hFFFFFFFF, 1);
        checkFrame(32'hFFFFFFFF, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
